// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the scan sequencer: line count and FSM encoding.
package scan_sequencer_pkg;

  localparam int LINES = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/scan_sequencer_next_set_bit.sv
// Combinational search over a line mask: the lowest set bit strictly above
// cur_i, and the lowest set bit overall (used for the first line and for wrap).
module next_set_bit
  import scan_sequencer_pkg::*;
(
  input  logic [LINES-1:0] mask_i,
  input  logic [IDX_W-1:0] cur_i,
  output logic [IDX_W-1:0] nxt_o,
  output logic             found_above_o,
  output logic [IDX_W-1:0] first_o
);

  // Descending walk so that the last hit written is the lowest qualifying bit.
  always_comb begin
    nxt_o         = '0;
    found_above_o = 1'b0;
    first_o       = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        first_o = IDX_W'(i);
        if (i > int'(cur_i)) begin
          nxt_o         = IDX_W'(i);
          found_above_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: walks the set bits of a latched 16-bit mask in ascending
// order, holding each line index on i0..i3 with EN high for a programmable
// dwell. Single pass ends with a one-cycle done pulse; loop mode wraps forever.
//
// Handshake: start is a single-cycle request sampled only in IDLE; it is
// accepted on the edge where start=1 and stop=0, and busy rises on the
// following cycle (except for an empty mask, which goes straight to DONE).
// stop is level-sampled and aborts a running scan on the next edge.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_mode,
  input  logic [LINES-1:0]   mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               i0,
  output logic               i1,
  output logic               i2,
  output logic               i3,
  output logic               EN,
  output logic               busy,
  output logic               line_done,
  output logic               done,
  output state_e             state_dbg
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               line_done_q, line_done_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [LINES-1:0]   mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loop_q, loop_d;

  logic [LINES-1:0]   search_mask;
  logic [IDX_W-1:0]   nxt_idx;
  logic               found_above;
  logic [IDX_W-1:0]   first_idx;

  // A dwell of 0 behaves like 1; the counter holds (cycles - 1).
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] dw);
    return (dw == '0) ? '0 : dw - DWELL_W'(1);
  endfunction

  // In IDLE the first line must come from the live mask input, since the
  // latch is only written on the accepting edge.
  assign search_mask = (state_q == ST_IDLE) ? mask : mask_q;

  next_set_bit u_next_set_bit (
    .mask_i        (search_mask),
    .cur_i         (idx_q),
    .nxt_o         (nxt_idx),
    .found_above_o (found_above),
    .first_o       (first_idx)
  );

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so all ports come straight from flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    loop_d  = loop_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          mask_d  = mask;
          dwell_d = dwell;
          loop_d  = loop_mode;
          if (mask != '0) begin
            state_d = ST_DRIVE;
            en_d    = 1'b1;
            busy_d  = 1'b1;
            idx_d   = first_idx;
            cnt_d   = dwell_reload(dwell);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (stop) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (found_above) begin
          idx_d = nxt_idx;
          cnt_d = dwell_reload(dwell_q);
        end else if (loop_q) begin
          idx_d = first_idx;
          cnt_d = dwell_reload(dwell_q);
        end else begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    line_done_d = (state_d == ST_DRIVE) && (cnt_d == '0);
  end

  // State, counter, latches and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      mask_q      <= '0;
      dwell_q     <= '0;
      loop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      line_done_q <= line_done_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
      loop_q      <= loop_d;
    end
  end

  assign {i0, i1, i2, i3} = idx_q;
  assign EN        = en_q;
  assign busy      = busy_q;
  assign line_done = line_done_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: per-cycle expected output vectors are produced by
// a line-list model when a scan is launched and checked as the DUT runs.
module tb_scan_sequencer;
  import scan_sequencer_pkg::*;

  localparam int DWELL_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               loop_mode = 1'b0;
  logic [15:0]        mask = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               i0, i1, i2, i3, EN, busy, line_done, done;
  state_e             state_dbg;

  scan_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop_mode (loop_mode),
    .mask      (mask),
    .dwell     (dwell),
    .i0        (i0),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .EN        (EN),
    .busy      (busy),
    .line_done (line_done),
    .done      (done),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  // Vector layout: {EN, busy, line_done, done, idx[3:0]}
  logic [7:0] exp_q[$];

  function automatic logic [7:0] mk(input logic en, input logic [3:0] idx,
                                    input logic bsy, input logic ld, input logic dn);
    return {en, bsy, ld, dn, idx};
  endfunction

  function automatic logic [15:0] decode(input logic en, input logic [3:0] idx);
    logic [15:0] one;
    one = 16'h0001;
    return en ? (one << idx) : 16'h0000;
  endfunction

  // Reference scan: ascending set-bit list, each held max(dwell,1) cycles.
  // First pushed vector is the cycle in which start is driven (still idle).
  task automatic push_scan(input logic [15:0] m, input int dw, input logic lp,
                           input int visits);
    int lines[$];
    int d;
    int l;
    exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    if (m == 16'h0000) begin
      exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
      return;
    end
    d = (dw == 0) ? 1 : dw;
    for (int b = 0; b < 16; b++) if (m[b]) lines.push_back(b);
    if (!lp) begin
      foreach (lines[j])
        for (int k = 0; k < d; k++)
          exp_q.push_back(mk(1'b1, 4'(lines[j]), 1'b1, k == d - 1, 1'b0));
      exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
    end else begin
      for (int v = 0; v < visits; v++) begin
        l = lines[v % lines.size()];
        for (int k = 0; k < d; k++)
          exp_q.push_back(mk(1'b1, 4'(l), 1'b1, k == d - 1, 1'b0));
      end
    end
    exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
  endtask

  // Monitor: mid-cycle, pop one expected vector per cycle while any remain,
  // and check the decoder view of the outputs alongside.
  always @(negedge clk) begin
    logic [7:0]  e;
    logic [7:0]  o;
    logic [15:0] d_obs;
    logic [15:0] d_exp;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = {EN, busy, line_done, done, i0, i1, i2, i3};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL cycle_out t=%0t got EN=%0b busy=%0b ld=%0b done=%0b idx=%0d want EN=%0b busy=%0b ld=%0b done=%0b idx=%0d",
                 $time, o[7], o[6], o[5], o[4], o[3:0], e[7], e[6], e[5], e[4], e[3:0]);
      end
      d_obs = decode(EN, {i0, i1, i2, i3});
      d_exp = decode(e[7], e[3:0]);
      checks++;
      if (d_obs !== d_exp) begin
        errors++;
        $display("FAIL decoder t=%0t got d=%h want d=%h", $time, d_obs, d_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    next_cycle();
  endtask

  task automatic launch(input logic [15:0] m, input int dw, input logic lp);
    mask      = m;
    dwell     = DWELL_W'(dw);
    loop_mode = lp;
    start     = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if ({EN, busy, line_done, done, i0, i1, i2, i3} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000",
               {EN, busy, line_done, done, i0, i1, i2, i3});
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_pass();
    launch(16'h8421, 2, 1'b0);
    push_scan(16'h8421, 2, 1'b0, 0);
    next_cycle();
    start = 1'b0;
    wait_drain(100);
  endtask

  task automatic test_empty_mask();
    launch(16'h0000, 3, 1'b0);
    push_scan(16'h0000, 3, 1'b0, 0);
    next_cycle();
    start = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_loop_stop();
    int visits = 6;
    launch(16'h8001, 1, 1'b1);
    push_scan(16'h8001, 1, 1'b1, visits);
    next_cycle();
    start = 1'b0;
    repeat (visits - 1) next_cycle();
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_dwell_zero();
    launch(16'h0006, 0, 1'b0);
    push_scan(16'h0006, 0, 1'b0, 0);
    next_cycle();
    start = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_stop_beats_start();
    launch(16'h0001, 1, 1'b0);
    stop = 1'b1;
    repeat (3) exp_q.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    next_cycle();
    start = 1'b0;
    stop  = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_midscan_changes();
    launch(16'h8421, 3, 1'b0);
    push_scan(16'h8421, 3, 1'b0, 0);
    next_cycle();
    start = 1'b0;
    next_cycle();
    launch(16'hFFFF, 7, 1'b1);
    next_cycle();
    start = 1'b0;
    wait_drain(100);
  endtask

  task automatic test_midscan_reset();
    launch(16'h00F0, 2, 1'b0);
    next_cycle();
    start = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({EN, busy, i0, i1, i2, i3} !== 6'b11_0100) begin
      errors++;
      $display("FAIL pre_reset_scan got %b want 110100", {EN, busy, i0, i1, i2, i3});
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({EN, busy, line_done, done, i0, i1, i2, i3} !== 8'h00) begin
      errors++;
      $display("FAIL midscan_reset_outputs got %b want 00000000",
               {EN, busy, line_done, done, i0, i1, i2, i3});
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL midscan_reset_state got %0d want %0d", state_dbg, ST_IDLE);
    end
    next_cycle();
    launch(16'h0A00, 1, 1'b0);
    push_scan(16'h0A00, 1, 1'b0, 0);
    next_cycle();
    start = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_random();
    logic [15:0] m;
    int          dw;
    for (int r = 0; r < 5; r++) begin
      m  = 16'($urandom_range(0, 16'hFFFF));
      dw = $urandom_range(0, 3);
      launch(m, dw, 1'b0);
      push_scan(m, dw, 1'b0, 0);
      next_cycle();
      start = 1'b0;
      wait_drain(200);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_empty_mask();
    test_loop_stop();
    test_dwell_zero();
    test_stop_beats_start();
    test_midscan_changes();
    test_midscan_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
